// File: rtl/ifetch_ctrl_pkg.sv
// Shared fetch-sequencer definitions: bus widths, reset level, start PC and FSM encodings.
// Optional build macro for the whole slice: IFETCH_PERF_EN (performance counters).
package ifetch_ctrl_pkg;

    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;

    localparam logic        RST_ACT  = 1'b1;
    localparam logic [63:0] START_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-fetch bus: request/ready handshake plus a one-cycle response strobe.
interface ifetch_ctrl_if
    import ifetch_ctrl_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
);

    logic              if_req_valid;
    logic [PC_W-1:0]   if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [INST_W-1:0] if_rsp_data;

    modport master (
        output if_req_valid,
        output if_req_addr,
        input  if_req_ready,
        input  if_rsp_valid,
        input  if_rsp_data
    );

    modport slave (
        input  if_req_valid,
        input  if_req_addr,
        output if_req_ready,
        output if_rsp_valid,
        output if_rsp_data
    );

endinterface

// File: rtl/ifetch_ctrl_redir_arb.sv
// EX/ID redirect arbiter: EX is the older instruction, so its target always wins.
module redir_arb
    import ifetch_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            id_valid,
    input  logic [PC_W-1:0] id_pc,
    output logic            ena,
    output logic [PC_W-1:0] pc
);

    always_comb begin
        ena = ex_valid | id_valid;
        pc  = '0;
        if (ex_valid)
            pc = ex_pc;
        else if (id_valid)
            pc = id_pc;
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer between PC register, fetch bus and IF/ID: one outstanding fetch, PC stall, redirect flush.
// Define IFETCH_PERF_EN to add the fetch/flush/stall performance counters and their ports.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              ex_redir_valid,
    input  logic [PC_W-1:0]   ex_redir_pc,
    input  logic              id_redir_valid,
    input  logic [PC_W-1:0]   id_redir_pc,
    input  logic              pipe_stall,
    ifetch_ctrl_if.master     bus,
    output logic              redir_ena_o,
    output logic [PC_W-1:0]   redir_pc_o,
    output logic              pc_stall_o,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   inst_pc_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_flush_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);

    fetch_state_e      state, state_nxt;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
    logic [INST_W-1:0] inst_buf_q, inst_buf_d;
    logic              redir;
    logic              xfer;

    redir_arb #(.PC_W(PC_W)) u_redir_arb (
        .ex_valid (ex_redir_valid),
        .ex_pc    (ex_redir_pc),
        .id_valid (id_redir_valid),
        .id_pc    (id_redir_pc),
        .ena      (redir),
        .pc       (redir_pc_o)
    );

    assign redir_ena_o = redir;

    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            state      <= ST_IDLE;
            inst_pc_q  <= '0;
            inst_buf_q <= '0;
        end else begin
            state      <= state_nxt;
            inst_pc_q  <= inst_pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    always_comb begin
        state_nxt        = state;
        inst_pc_d        = inst_pc_q;
        inst_buf_d       = inst_buf_q;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = '0;
        inst_valid_o     = 1'b0;
        inst_o           = '0;
        inst_pc_o        = '0;

        case (state)
            ST_IDLE: state_nxt = ST_REQ;

            // Address follows pc_i live; the bus samples it only in the ready cycle.
            ST_REQ: begin
                bus.if_req_valid = 1'b1;
                bus.if_req_addr  = pc_i;
                if (bus.if_req_ready) begin
                    if (redir) begin
                        state_nxt = ST_DISCARD;
                    end else begin
                        state_nxt = ST_WAIT;
                        inst_pc_d = pc_i;
                    end
                end
            end

            // Response is bypassed straight to IF/ID and also buffered in case IF/ID stalls.
            ST_WAIT: begin
                if (bus.if_rsp_valid) begin
                    if (redir) begin
                        state_nxt = ST_REQ;
                    end else begin
                        inst_valid_o = 1'b1;
                        inst_o       = bus.if_rsp_data;
                        inst_pc_o    = inst_pc_q;
                        inst_buf_d   = bus.if_rsp_data;
                        state_nxt    = pipe_stall ? ST_HOLD : ST_REQ;
                    end
                end else if (redir) begin
                    state_nxt = ST_DISCARD;
                end
            end

            ST_HOLD: begin
                if (redir) begin
                    state_nxt = ST_REQ;
                end else begin
                    inst_valid_o = 1'b1;
                    inst_o       = inst_buf_q;
                    inst_pc_o    = inst_pc_q;
                    if (!pipe_stall)
                        state_nxt = ST_REQ;
                end
            end

            // The in-flight response belongs to a squashed path; swallow it.
            ST_DISCARD: begin
                if (bus.if_rsp_valid)
                    state_nxt = ST_REQ;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign xfer       = inst_valid_o & ~pipe_stall & ~redir;
    assign pc_stall_o = ~xfer;

`ifdef IFETCH_PERF_EN
    logic drop;

    // A redirect kills a just-accepted request, an in-flight fetch or a held instruction.
    assign drop = redir & (((state == ST_REQ) & bus.if_req_ready) |
                           (state == ST_WAIT) | (state == ST_HOLD));

    always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {63'd0, xfer};
            perf_flush_cnt <= perf_flush_cnt + {63'd0, drop};
            perf_stall_cnt <= perf_stall_cnt + {63'd0, inst_valid_o & pipe_stall};
        end
    end
`endif

endmodule
